// File: rtl/serial_sub16_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding and default operand width.
package serial_sub16_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int SUB_WIDTH = 16;

endpackage

// File: rtl/serial_sub16_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout = borrow.
// Purely combinational; reused one bit per clock by serial_sub16.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub16.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// start/ready/done handshake; results held until the next completion.
module serial_sub16
  import serial_sub16_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0]    cnt;
  logic             br, d, br_nx, last;

  full_subtractor u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (d),
    .bout (br_nx)
  );

  assign last  = (cnt == LAST);
  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // br on the final edge is the borrow into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
            res <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nx;
          cnt <= cnt + 1'b1;
          res <= {d, res[WIDTH-1:1]};
          if (last) begin
            diff     <= {d, res[WIDTH-1:1]};
            bout     <= br_nx;
            overflow <= br ^ br_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub16.sv
// Self-checking bench for serial_sub16.
// Arithmetic reference model plus directed literal vectors.
module tb_serial_sub16;

  localparam int W = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  a, b;
  logic          bin;
  logic          ready, done, bout, overflow;
  logic [W-1:0]  diff;

  logic fa, fb, fbin, fd, fbo;

  int errors = 0;
  int checks = 0;

  serial_sub16 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .ready    (ready),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow)
  );

  full_subtractor u_fs (
    .a    (fa),
    .b    (fb),
    .bin  (fbin),
    .d    (fd),
    .bout (fbo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: busy countdown plus plain integer arithmetic.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [W-1:0] ma = '0, mb = '0;
  logic         mbin = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         m_bout = 1'b0, m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    int r, s;
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_diff  = '0;
      m_bout  = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_phase == 0) begin
      if (start === 1'b1) begin
        ma      = a;
        mb      = b;
        mbin    = bin;
        m_left  = W;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin
        r = int'(ma) - int'(mb) - int'(mbin);
        s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        m_diff  = r[W-1:0];
        m_bout  = (r < 0);
        m_ovf   = (s > 32767) || (s < -32768);
        m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    chk("m_ready", ready, m_phase == 0);
    chk("m_done", done, m_phase == 2);
    chk("m_diff", diff, m_diff);
    chk("m_bout", bout, m_bout);
    chk("m_ovf", overflow, m_ovf);
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                        input logic tbin, input bit lit,
                        input logic [W-1:0] ed, input logic eb,
                        input logic eo, input string nm);
    int n;
    bit seen;
    @(negedge clk);
    a = ta; b = tb2; bin = tbin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    n = 1;
    seen = 0;
    while (!seen && n < 40) begin
      if (done) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({nm, "_lat"}, n, W + 1);
    if (lit) begin
      chk({nm, "_diff"}, diff, ed);
      chk({nm, "_bout"}, bout, eb);
      chk({nm, "_ovf"}, overflow, eo);
    end
    @(negedge clk);
    if (lit) begin
      chk({nm, "_rdy"}, ready, 1);
      chk({nm, "_done0"}, done, 0);
    end
  endtask

  initial begin
    int n, pulses;
    logic [W-1:0] got;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    fa = 0; fb = 0; fbin = 0;

    for (int i = 0; i < 8; i++) begin
      int ea, eb2, ebi;
      ea = (i >> 2) & 1; eb2 = (i >> 1) & 1; ebi = i & 1;
      fa = 1'(ea); fb = 1'(eb2); fbin = 1'(ebi);
      #1;
      chk("fs_d", fd, (ea - eb2 - ebi) & 1);
      chk("fs_bout", fbo, ea < eb2 + ebi);
    end

    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    run_op(16'h0005, 16'h0003, 0, 1, 16'h0002, 0, 0, "t1");
    run_op(16'h0000, 16'h0001, 0, 1, 16'hFFFF, 1, 0, "t2");
    run_op(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 0, 1, "t3");
    run_op(16'h7FFF, 16'hFFFF, 0, 1, 16'h8000, 1, 1, "t4a");
    run_op(16'h0010, 16'h0010, 1, 1, 16'hFFFF, 1, 0, "t4b");

    // Start pulse while busy must be ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h0034; bin = 0; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    pulses = 0;
    got = '0;
    for (n = 1; n <= 25; n++) begin
      if (n == 5) begin start = 1; a = 16'hFFFF; b = 16'h0000; end
      if (n == 6) start = 0;
      if (done) begin pulses++; got = diff; end
      @(negedge clk);
    end
    chk("t5_pulses", pulses, 1);
    chk("t5_diff", got, 16'h1200);
    chk("t5_bout", bout, 0);
    chk("t5_ovf", overflow, 0);

    // Abort at bit 8 with an asynchronous reset.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h1111; bin = 0; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_ready", ready, 1);
    chk("t6_done", done, 0);
    chk("t6_diff", diff, 0);
    chk("t6_bout", bout, 0);
    chk("t6_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0003, 16'h0007, 0, 1, 16'hFFFC, 1, 0, "t6b");

    // start held high: back-to-back ops every W+2 cycles.
    @(negedge clk);
    a = 16'h0100; b = 16'h0001; bin = 0; start = 1;
    @(posedge clk);
    pulses = 0;
    for (n = 1; n <= 36; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    start = 0;
    chk("hold_pulses", pulses, 2);
    chk("hold_diff", diff, 16'h00FF);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 1000; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0, '0, 0, 0, "rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
